// File: rtl/spi_counter_slave_rx_if.sv
// SPI link signals between the counter master and the slave receiver.
//   i_sclk : SPI clock from master (asynchronous to the slave's clk)
//   i_mosi : serial data master -> slave, MSB first
//   i_cs_n : chip select, active low
//   o_miso : serial echo slave -> master
interface spi_counter_slave_rx_if;
   logic i_sclk;
   logic i_mosi;
   logic i_cs_n;
   logic o_miso;

   modport master (output i_sclk, output i_mosi, output i_cs_n, input o_miso);
   modport slave  (input i_sclk, input i_mosi, input i_cs_n, output o_miso);
endinterface

// File: rtl/spi_counter_slave_rx.sv
// SPI mode-0 slave receiver for the counter link. A 2-byte frame (high byte,
// then low byte, MSB first) rebuilds a 14-bit counter value. The previously
// committed value is echoed on MISO during the next frame.
// Ports:
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   spi         : SPI pins (slave modport: i_sclk, i_mosi, i_cs_n in; o_miso out)
//   o_counter   : last committed counter value
//   o_valid     : one-cycle pulse when o_counter updates
//   o_frame_err : one-cycle pulse on a rejected or aborted frame
//   o_busy      : high while a frame is in progress
module spi_counter_slave_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_WIDTH   = 14
) (
   input  logic                   clk,
   input  logic                   reset,
   spi_counter_slave_rx_if.slave  spi,
   output logic [CNT_WIDTH-1:0]   o_counter,
   output logic                   o_valid,
   output logic                   o_frame_err,
   output logic                   o_busy
);

   typedef enum logic [1:0] {IDLE, RX_HI, RX_LO, DONE} state_t;

   // synchronizers and edge detection
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic                   sclk_dly_q, sclk_dly_d;
   logic                   cs_dly_q, cs_dly_d;
   logic [SYNC_STAGES:0]   armed_q, armed_d;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_rise, sclk_fall, cs_fall;

   // receive / transmit state
   state_t                 state_q, state_d;
   logic [7:0]             shift_q, shift_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             hi_byte_q, hi_byte_d;
   logic [7:0]             tx_q, tx_d;
   logic                   tx_hold_q, tx_hold_d;
   logic [CNT_WIDTH-1:0]   counter_q, counter_d;
   logic                   valid_q, valid_d;
   logic                   frame_err_q, frame_err_d;
   logic [7:0]             rx_byte;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;
   // The cs_n chain resets to 1, so if the pin is already low when reset is
   // released the chain draining to 0 looks like a falling edge. armed_q
   // masks cs_fall until both the synced value and its delayed copy come from
   // real pin samples, so a frame in progress at reset release is ignored.
   assign cs_fall = armed_q[SYNC_STAGES] & cs_dly_q & ~cs_s;

   assign rx_byte = {shift_q[6:0], mosi_s};

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.i_sclk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.i_mosi};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi.i_cs_n};
      sclk_dly_d  = sclk_s;
      cs_dly_d    = cs_s;
      armed_d     = {armed_q[SYNC_STAGES-1:0], 1'b1};
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      hi_byte_d   = hi_byte_q;
      tx_d        = tx_q;
      tx_hold_d   = tx_hold_q;
      counter_d   = counter_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d   = RX_HI;
               bit_cnt_d = '0;
               tx_hold_d = 1'b0;
               tx_d      = {2'b00, counter_q[13:8]};
            end
         end

         RX_HI: begin
            if (cs_s) begin
               state_d     = IDLE;
               frame_err_d = (bit_cnt_q != 3'd0);
            end else if (sclk_rise) begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  hi_byte_d = rx_byte;
                  bit_cnt_d = '0;
                  state_d   = RX_LO;
                  // The low byte is loaded on the 8th rise, but the following
                  // fall still belongs to the high byte; hold off that one
                  // shift so low-byte bit 7 is on MISO for the 9th rise.
                  tx_d      = counter_q[7:0];
                  tx_hold_d = 1'b1;
               end
            end else if (sclk_fall) begin
               tx_d = {tx_q[6:0], 1'b0};
            end
         end

         RX_LO: begin
            // A completed 16th bit takes priority over a same-cycle abort.
            if (sclk_rise && (bit_cnt_q == 3'd7)) begin
               shift_d   = rx_byte;
               bit_cnt_d = '0;
               state_d   = DONE;
               if (hi_byte_q[7:6] == 2'b00) begin
                  counter_d = {hi_byte_q[5:0], rx_byte};
                  valid_d   = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else if (cs_s) begin
               state_d     = IDLE;
               frame_err_d = 1'b1;
            end else if (sclk_rise) begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
            end else if (sclk_fall) begin
               if (tx_hold_q) begin
                  tx_hold_d = 1'b0;
               end else begin
                  tx_d = {tx_q[6:0], 1'b0};
               end
            end
         end

         DONE: begin
            if (cs_s) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
         sclk_dly_q  <= 1'b0;
         cs_dly_q    <= 1'b1;
         armed_q     <= '0;
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         hi_byte_q   <= '0;
         tx_q        <= '0;
         tx_hold_q   <= 1'b0;
         counter_q   <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cs_sync_q   <= cs_sync_d;
         sclk_dly_q  <= sclk_dly_d;
         cs_dly_q    <= cs_dly_d;
         armed_q     <= armed_d;
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         hi_byte_q   <= hi_byte_d;
         tx_q        <= tx_d;
         tx_hold_q   <= tx_hold_d;
         counter_q   <= counter_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign spi.o_miso  = ((state_q == RX_HI) || (state_q == RX_LO)) ? tx_q[7] : 1'b0;
   assign o_counter   = counter_q;
   assign o_valid     = valid_q;
   assign o_frame_err = frame_err_q;
   assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_counter_slave_rx.sv
// Directed bench for spi_counter_slave_rx: 1 MHz SPI frames against a 100 MHz
// clk, with hand-computed counter values, MISO echoes and pulse counts.
module tb_spi_counter_slave_rx;

   logic        clk;
   logic        reset;
   logic [13:0] o_counter;
   logic        o_valid;
   logic        o_frame_err;
   logic        o_busy;

   spi_counter_slave_rx_if spi_if ();

   spi_counter_slave_rx #(
      .SYNC_STAGES (2),
      .CNT_WIDTH   (14)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .spi         (spi_if.slave),
      .o_counter   (o_counter),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int rise_cyc = 0;
   int last_valid_cyc = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_valid) begin
         valid_cnt++;
         last_valid_cyc = cyc;
      end
      if (o_frame_err) err_cnt++;
      if (o_valid && o_frame_err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One SPI bit: data set during the low phase, MISO sampled just before the rise.
   task automatic spi_bit(input logic b, output logic m);
      spi_if.i_mosi = b;
      repeat (50) @(negedge clk);
      m = spi_if.o_miso;
      spi_if.i_sclk = 1'b1;
      rise_cyc = cyc;
      repeat (50) @(negedge clk);
      spi_if.i_sclk = 1'b0;
   endtask

   // Full CS-framed transfer of nbits taken MSB-first from data[23:...].
   task automatic spi_xfer(input logic [23:0] data, input int unsigned nbits,
                           output logic [23:0] miso);
      logic m;
      miso = '0;
      @(negedge clk);
      spi_if.i_cs_n = 1'b0;
      repeat (50) @(negedge clk);
      for (int unsigned i = 0; i < nbits; i++) begin
         spi_bit(data[23-i], m);
         miso[23-i] = m;
      end
      repeat (20) @(negedge clk);
      spi_if.i_cs_n = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      logic [23:0] mi;
      logic        m;
      int          v0, e0, lat;

      reset         = 1'b1;
      spi_if.i_sclk = 1'b0;
      spi_if.i_mosi = 1'b0;
      spi_if.i_cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_counter",   32'(o_counter),   32'd0);
      check("rst_valid",     32'(o_valid),     32'd0);
      check("rst_frame_err", 32'(o_frame_err), 32'd0);
      check("rst_miso",      32'(spi_if.o_miso), 32'd0);
      check("rst_busy",      32'(o_busy),      32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // 0x00,0x05 -> 5, one valid pulse, short latency
      v0 = valid_cnt; e0 = err_cnt;
      spi_xfer({8'h00, 8'h05, 8'h00}, 16, mi);
      lat = last_valid_cyc - rise_cyc;
      check("f005_valid",   32'(valid_cnt - v0), 32'd1);
      check("f005_err",     32'(err_cnt - e0),   32'd0);
      check("f005_counter", 32'(o_counter),      32'd5);
      check("f005_lat_le4", 32'((lat >= 1) && (lat <= 4)), 32'd1);

      // 0xC0,0x01 -> rejected, counter holds 5
      v0 = valid_cnt; e0 = err_cnt;
      spi_xfer({8'hC0, 8'h01, 8'h00}, 16, mi);
      check("fc0_err",     32'(err_cnt - e0),   32'd1);
      check("fc0_valid",   32'(valid_cnt - v0), 32'd0);
      check("fc0_counter", 32'(o_counter),      32'd5);

      // 0x27,0x0F -> 9999, echo of 5
      spi_xfer({8'h27, 8'h0F, 8'h00}, 16, mi);
      check("f270f_counter", 32'(o_counter), 32'd9999);
      check("f270f_echo",    32'(mi[23:8]),  32'h0005);

      // 0x00,0x00 -> 0, echo of 9999
      v0 = valid_cnt;
      spi_xfer({8'h00, 8'h00, 8'h00}, 16, mi);
      check("f0000_counter", 32'(o_counter),      32'd0);
      check("f0000_echo",    32'(mi[23:8]),       32'h270F);
      check("f0000_valid",   32'(valid_cnt - v0), 32'd1);

      // 16383 then 0 (wrap accepted)
      spi_xfer({8'h3F, 8'hFF, 8'h00}, 16, mi);
      check("f3fff_counter", 32'(o_counter), 32'd16383);
      v0 = valid_cnt;
      spi_xfer({8'h00, 8'h00, 8'h00}, 16, mi);
      check("wrap_counter", 32'(o_counter),      32'd0);
      check("wrap_echo",    32'(mi[23:8]),       32'h3FFF);
      check("wrap_valid",   32'(valid_cnt - v0), 32'd1);

      spi_xfer({8'h12, 8'h34, 8'h00}, 16, mi);
      check("f1234_counter", 32'(o_counter), 32'h1234);

      // abort after 11 bits -> error, no update
      v0 = valid_cnt; e0 = err_cnt;
      spi_xfer({8'h00, 8'h09, 8'h00}, 11, mi);
      check("abort_err",     32'(err_cnt - e0),   32'd1);
      check("abort_valid",   32'(valid_cnt - v0), 32'd0);
      check("abort_counter", 32'(o_counter),      32'h1234);

      spi_xfer({8'h00, 8'h03, 8'h00}, 16, mi);
      check("f0003_counter", 32'(o_counter), 32'd3);

      // CS pulse with no SCLK edges is silent
      e0 = err_cnt;
      spi_xfer(24'h0, 0, mi);
      check("silent_cs_err", 32'(err_cnt - e0), 32'd0);

      // three bytes in one CS: extra byte ignored
      v0 = valid_cnt; e0 = err_cnt;
      spi_xfer({8'h00, 8'h07, 8'hFF}, 24, mi);
      check("f3b_counter", 32'(o_counter),      32'd7);
      check("f3b_valid",   32'(valid_cnt - v0), 32'd1);
      check("f3b_err",     32'(err_cnt - e0),   32'd0);

      // reset at bit 4 of a frame; the remainder must be ignored
      v0 = valid_cnt; e0 = err_cnt;
      @(negedge clk);
      spi_if.i_cs_n = 1'b0;
      repeat (50) @(negedge clk);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, m);
      check("rstmid_busy_before", 32'(o_busy), 32'd1);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) spi_bit(i[0], m);
      repeat (20) @(negedge clk);
      check("rstmid_busy_during", 32'(o_busy), 32'd0);
      spi_if.i_cs_n = 1'b1;
      repeat (20) @(negedge clk);
      check("rstmid_counter", 32'(o_counter),      32'd0);
      check("rstmid_valid",   32'(valid_cnt - v0), 32'd0);
      check("rstmid_err",     32'(err_cnt - e0),   32'd0);

      check("valid_err_overlap", 32'(both_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_counter_slave_rx.md
Name: spi_counter_slave_rx

Overview:
SPI mode-0 slave receiver at the far end of the master counter link. It takes a 2-byte frame (high byte then low byte, MSB first) from the SPI master and rebuilds the 14-bit counter value that drives the FND display path. It also echoes the last committed value back on MISO during the next frame, so the master can check the link.

Parameters:
SYNC_STAGES, 2, number of flip-flop synchronizer stages on sclk, mosi and cs_n (minimum 2).
CNT_WIDTH, 14, width of the reconstructed counter. Fixed at 14 for a 2-byte frame; the high byte carries bits [13:8].

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  synchronous, active-high reset
i_sclk  input  1  SPI clock from master, asynchronous to clk
i_mosi  input  1  SPI data from master
i_cs_n  input  1  SPI chip select, active low
o_miso  output  1  SPI data to master
o_counter  output  14  last committed counter value
o_valid  output  1  one-cycle pulse when o_counter updates
o_frame_err  output  1  one-cycle pulse on a rejected or aborted frame
o_busy  output  1  high while a frame is in progress (state not IDLE)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: o_counter=0, o_valid=0, o_frame_err=0, o_miso=0, o_busy=0, state=IDLE. Synchronizer stages for cs_n reset to 1; stages for sclk and mosi reset to 0.
- Synchronization: i_sclk, i_mosi and i_cs_n each pass through SYNC_STAGES flops. sclk_rise, sclk_fall and cs_fall are single-cycle strobes from the synced signals and their one-cycle-delayed copies.
- Master timing: the master guarantees an SCLK high time and low time of at least SYNC_STAGES+2 clk cycles each.
- States:
  - IDLE: go to RX_HI on cs_fall. No other edge leaves IDLE. Because of this, a frame already in progress when reset is released is ignored until the next CS falling edge.
  - RX_HI: on each sclk_rise, shift synced mosi into shift_reg (MSB first) and increment the 3-bit bit_cnt. When the 8th bit is taken, latch hi_byte, clear bit_cnt and go to RX_LO.
  - RX_LO: same shifting. When the 8th bit is taken, go to DONE and evaluate the frame in the same cycle:
    - if hi_byte[7:6]==2'b00, set o_counter <= {hi_byte[5:0], rx_byte} and pulse o_valid on the next cycle;
    - otherwise pulse o_frame_err and leave o_counter unchanged.
  - DONE: ignore all further SCLK edges and extra bytes. Go to IDLE when synced cs_n is high.
- Abort: if synced cs_n goes high in RX_HI or RX_LO, go to IDLE with no commit. Pulse o_frame_err if any bit was received (bit_cnt!=0 or state is RX_LO); a CS pulse with no SCLK edges is silent.
- Latency: o_valid asserts at most SYNC_STAGES+2 clk cycles after the 16th SCLK rising edge at the pin.
- MISO echo:
  - On cs_fall, load tx_reg with {2'b00, o_counter[13:8]}; o_miso shows bit 7 immediately.
  - On each sclk_fall in RX_HI or RX_LO, shift tx_reg left and drive the new MSB.
  - At the RX_HI to RX_LO transition, load tx_reg with o_counter[7:0] (the pre-commit value).
  - In IDLE and DONE, o_miso=0.
- Simultaneous events: if a commit and an abort fall in the same cycle, the commit wins (the 16th bit completed first). o_valid and o_frame_err are never high together.
- Wrap-around: a value of 16383 followed by 0 is accepted as a normal update; the block does no monotonicity check.

Test Plan:
- Reset held 10 cycles with cs_n high → o_counter=0, o_valid=0, o_frame_err=0, o_miso=0, o_busy=0.
- Frame 0x00,0x05 at 1 MHz SCLK → exactly one o_valid pulse within 4 clks of the 16th SCLK rise; o_counter=5.
- Frame 0x27,0x0F → o_counter=9999. A following frame 0x00,0x00 → MISO returns 0x27,0x0F and o_counter becomes 0.
- Frame 0xC0,0x01 → one o_frame_err pulse, no o_valid, o_counter holds its previous value.
- cs_n deasserted after 11 bits → o_frame_err pulse, no update. Next frame 0x00,0x03 → o_counter=3.
- Three bytes 0x00,0x07,0xFF in one CS → o_counter=7 and o_valid pulses once. Reset asserted at bit 4 of the next frame → o_counter=0 and the rest of that frame is ignored, with no o_valid and no o_frame_err.
